srfpu_pcpi_shell: RTL and testbench
===================================

# srfpu_pcpi_shell

Parametrised PCPI front-end for the stochastic-rounding FPU subsystem. Claims matching custom instructions from the PicoRV32 PCPI port and dispatches them to one of NUM_UNITS execution units over a req/done handshake. Returns results, accumulates sticky exception flags, guards each operation with a timeout watchdog, and supplies every unit with a shared LFSR random stream for stochastic rounding. Sits between the CPU core and the FPU datapaths, replacing the single-core hard-wired hookup.

## Interface
- NUM_UNITS, 2, execution units attached (1..8); unit index = insn funct3
- NUM_ROUND_BITS, 10, random bits per cycle to units (1..32)
- OPCODE, 7'b1010011, major opcode claimed
- TIMEOUT_CYCLES, 256, max WAIT cycles before forced completion (>=2)
- RAND_SEED, 32'hACE1_2468, LFSR reset value (nonzero)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pcpi_valid / pcpi_insn / pcpi_rs1 / pcpi_rs2  in  1/32/32/32  PCPI request
- pcpi_wr / pcpi_rd / pcpi_wait / pcpi_ready  out  1/32/1/1  PCPI response
- unit_req  out  NUM_UNITS  one-hot one-cycle start pulse
- unit_op  out  7  latched funct7
- unit_a, unit_b  out  32  latched rs1/rs2
- unit_rand  out  NUM_ROUND_BITS  LFSR low bits
- unit_done  in  NUM_UNITS  completion pulse
- unit_res  in  NUM_UNITS*32  results, unit i at [32i+:32]
- unit_flags  in  NUM_UNITS*5  {NV,DZ,OF,UF,NX} per unit
- fflags  out  5  sticky accumulated flags
- fflags_clr  in  1  clear fflags
- timeout_err  out  1  sticky, set on watchdog expiry
- state_test  out  2  current FSM state

All outputs reset to 0 except unit_rand (RAND_SEED low bits).

## Operation
- States IDLE(0), ISSUE(1), WAIT(2), RESP(3).
- IDLE: claim when pcpi_valid, insn[6:0]==OPCODE, funct3<NUM_UNITS; latch rs1, rs2, funct7, sel=funct3; -> ISSUE. Unclaimed: no output activity.
- ISSUE: unit_req[sel]=1 one cycle; clear watchdog; -> WAIT.
- WAIT: unit_done[sel] -> latch unit_res[sel], OR unit_flags[sel] into fflags, -> RESP. Done from other units ignored. Watchdog == TIMEOUT_CYCLES-1 without done -> result 32'h7FC00000, set fflags NV, set timeout_err, -> RESP.
- RESP: pcpi_ready=pcpi_wr=1, pcpi_rd=result, one cycle; -> IDLE.
- pcpi_wait high in ISSUE and WAIT only.
- pcpi_valid low in ISSUE/WAIT: abort -> IDLE, no response, later done discarded.
- IDLE ignores pcpi_valid the cycle right after RESP (re-claim guard).
- fflags_clr and new flags same cycle: new flags survive, old cleared.
- LFSR: 32-bit Galois, taps 32'h8020_0003, advances every cycle incl. reset release.
- reset mid-operation: return to IDLE immediately, all state to reset values.

## Timing
- valid sampled cycle 0 -> unit_req cycle 1 -> earliest done cycle 2 -> pcpi_ready cycle 3 (min latency 3).
- done asserted during ISSUE is ignored.
- Timeout: pcpi_ready at cycle TIMEOUT_CYCLES+2 after claim.
- Watchdog width $clog2(TIMEOUT_CYCLES+1); no wrap.

## Configuration
- SRFPU_PERF_CNT_EN defined: adds outputs perf_insn_cnt (32, completed responses incl. timeouts) and perf_busy_cnt (32, cycles not IDLE); reset 0; wrap 2^32-1 -> 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- srfpu_pkg: state enum, CANON_NAN 32'h7FC00000, flag bit indices, LFSR taps constant.
- Sub-module srfpu_lfsr (params WIDTH, SEED, TAPS; clk, reset, q).

## Test plan
- NUM_UNITS=2, insn funct3=1, rs1=32'h3F800000, unit1 done after 4 cycles res 32'h40000000 flags 5'b00001 -> pcpi_rd 32'h40000000, pcpi_wr, fflags 5'b00001, unit0 never requested.
- funct3=3 with NUM_UNITS=2 -> no wait/ready/req ever asserted.
- Unit never done, TIMEOUT_CYCLES=8 -> pcpi_ready at cycle 10, rd 32'h7FC00000, timeout_err=1, fflags[4]=1.
- pcpi_valid dropped in WAIT, then done -> no pcpi_ready, state IDLE, fflags unchanged.
- fflags_clr with simultaneous done flags 5'b00100 after prior 5'b00001 -> fflags 5'b00100.
- reset asserted in WAIT -> next edge state 0, pcpi_wait 0, LFSR reloads RAND_SEED.

Source files
------------

// File: rtl/srfpu_pkg.sv
// Shared types and constants for the stochastic-rounding FPU PCPI shell.
package srfpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } srfpu_state_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Flag vector layout is {NV,DZ,OF,UF,NX}
    localparam int unsigned FLAG_NV   = 4;
    localparam int unsigned FLAG_DZ   = 3;
    localparam int unsigned FLAG_OF   = 2;
    localparam int unsigned FLAG_UF   = 1;
    localparam int unsigned FLAG_NX   = 0;
    localparam int unsigned NUM_FLAGS = 5;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/srfpu_lfsr.sv
// Galois LFSR supplying the random stream used for stochastic rounding.
module srfpu_lfsr #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= SEED;
        else if (q[0])
            q <= (q >> 1) ^ TAPS;
        else
            q <= q >> 1;
    end

endmodule

// File: rtl/srfpu_pcpi_shell.sv
// PCPI front-end dispatching custom FP instructions to NUM_UNITS execution units.
// Optional performance counters are enabled with `define SRFPU_PERF_CNT_EN.
module srfpu_pcpi_shell
    import srfpu_pkg::*;
#(
    parameter int unsigned NUM_UNITS      = 2,
    parameter int unsigned NUM_ROUND_BITS = 10,
    parameter logic [6:0]  OPCODE         = 7'b1010011,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] RAND_SEED      = 32'hACE1_2468
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pcpi_valid,
    input  logic [31:0]                   pcpi_insn,
    input  logic [31:0]                   pcpi_rs1,
    input  logic [31:0]                   pcpi_rs2,
    output logic                          pcpi_wr,
    output logic [31:0]                   pcpi_rd,
    output logic                          pcpi_wait,
    output logic                          pcpi_ready,
    output logic [NUM_UNITS-1:0]          unit_req,
    output logic [6:0]                    unit_op,
    output logic [31:0]                   unit_a,
    output logic [31:0]                   unit_b,
    output logic [NUM_ROUND_BITS-1:0]     unit_rand,
    input  logic [NUM_UNITS-1:0]          unit_done,
    input  logic [NUM_UNITS*32-1:0]       unit_res,
    input  logic [NUM_UNITS*NUM_FLAGS-1:0] unit_flags,
    output logic [NUM_FLAGS-1:0]          fflags,
    input  logic                          fflags_clr,
    output logic                          timeout_err,
    output logic [1:0]                    state_test
`ifdef SRFPU_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_insn_cnt,
    output logic [31:0]                   perf_busy_cnt
`endif
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_FLAGS-1:0] NV_MASK = NUM_FLAGS'(1 << FLAG_NV);

    srfpu_state_e         state, state_nxt;
    logic [2:0]           sel;
    logic [31:0]          result;
    logic [WD_W-1:0]      wdog;
    logic                 prev_resp;
    logic                 claim, done_hit, tmo_hit;
    logic                 sel_done;
    logic [31:0]          sel_res;
    logic [NUM_FLAGS-1:0] sel_flags;
    logic [31:0]          lfsr_q;
    logic                 unused_bits;

    srfpu_lfsr #(
        .WIDTH (32),
        .SEED  (RAND_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign unit_rand   = lfsr_q[NUM_ROUND_BITS-1:0];
    assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], lfsr_q};

    always_comb begin
        sel_done  = 1'b0;
        sel_res   = '0;
        sel_flags = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (sel == 3'(i)) begin
                sel_done  = unit_done[i];
                sel_res   = unit_res[32*i +: 32];
                sel_flags = unit_flags[NUM_FLAGS*i +: NUM_FLAGS];
            end
        end
        // prev_resp blocks re-claiming the instruction the core is still retiring
        claim    = (state == ST_IDLE) && !prev_resp && pcpi_valid &&
                   (pcpi_insn[6:0] == OPCODE) &&
                   ({29'd0, pcpi_insn[14:12]} < 32'(NUM_UNITS));
        done_hit = (state == ST_WAIT) && pcpi_valid && sel_done;
        tmo_hit  = (state == ST_WAIT) && pcpi_valid && !sel_done && (wdog == WD_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (claim) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = pcpi_valid ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (!pcpi_valid)
                    state_nxt = ST_IDLE;
                else if (done_hit || tmo_hit)
                    state_nxt = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        unit_req   = '0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        state_test = state;
        case (state)
            ST_ISSUE: begin
                pcpi_wait = 1'b1;
                for (int unsigned i = 0; i < NUM_UNITS; i++)
                    unit_req[i] = (sel == 3'(i));
            end
            ST_WAIT:  pcpi_wait = 1'b1;
            ST_RESP: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                pcpi_rd    = result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel         <= '0;
            unit_op     <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            result      <= '0;
            wdog        <= '0;
            prev_resp   <= 1'b0;
            fflags      <= '0;
            timeout_err <= 1'b0;
        end else begin
            prev_resp <= (state == ST_RESP);
            if (claim) begin
                sel     <= pcpi_insn[14:12];
                unit_op <= pcpi_insn[31:25];
                unit_a  <= pcpi_rs1;
                unit_b  <= pcpi_rs2;
            end
            if (state == ST_ISSUE)
                wdog <= '0;
            else if (state == ST_WAIT && wdog != '1)
                wdog <= wdog + 1'b1;
            if (done_hit)
                result <= sel_res;
            else if (tmo_hit) begin
                result      <= CANON_NAN;
                timeout_err <= 1'b1;
            end
            // clear applies to the old value only; flags arriving now survive
            fflags <= (fflags_clr ? '0 : fflags) |
                      (done_hit ? sel_flags : '0) |
                      (tmo_hit ? NV_MASK : '0);
        end
    end

`ifdef SRFPU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_insn_cnt <= '0;
            perf_busy_cnt <= '0;
        end else begin
            if (state == ST_RESP)
                perf_insn_cnt <= perf_insn_cnt + 32'd1;
            if (state != ST_IDLE)
                perf_busy_cnt <= perf_busy_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_srfpu_pcpi_shell.sv
// Directed self-checking bench for srfpu_pcpi_shell (NUM_UNITS=2, TIMEOUT_CYCLES=8).
module tb_srfpu_pcpi_shell;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic [1:0]  unit_req;
    logic [6:0]  unit_op;
    logic [31:0] unit_a, unit_b;
    logic [9:0]  unit_rand;
    logic [1:0]  unit_done;
    logic [63:0] unit_res;
    logic [9:0]  unit_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        timeout_err;
    logic [1:0]  state_test;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    srfpu_pcpi_shell #(
        .NUM_UNITS      (2),
        .NUM_ROUND_BITS (10),
        .OPCODE         (7'b1010011),
        .TIMEOUT_CYCLES (8),
        .RAND_SEED      (32'hACE1_2468)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_rs1    (pcpi_rs1),
        .pcpi_rs2    (pcpi_rs2),
        .pcpi_wr     (pcpi_wr),
        .pcpi_rd     (pcpi_rd),
        .pcpi_wait   (pcpi_wait),
        .pcpi_ready  (pcpi_ready),
        .unit_req    (unit_req),
        .unit_op     (unit_op),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_rand   (unit_rand),
        .unit_done   (unit_done),
        .unit_res    (unit_res),
        .unit_flags  (unit_flags),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr),
        .timeout_err (timeout_err),
        .state_test  (state_test)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] opc);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    initial begin
        reset      = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = '0;
        pcpi_rs1   = '0;
        pcpi_rs2   = '0;
        unit_done  = '0;
        unit_res   = '0;
        unit_flags = '0;
        fflags_clr = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_state", 32'(state_test), 32'd0);
        check("rst_wait", 32'(pcpi_wait), 32'd0);
        check("rst_ready", 32'(pcpi_ready), 32'd0);
        check("rst_rd", pcpi_rd, 32'd0);
        check("rst_req", 32'(unit_req), 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        check("rst_rand", 32'(unit_rand), 32'h068);

        // LFSR sequence from the seed
        reset = 1'b0;
        tick(); check("lfsr1", 32'(unit_rand), 32'h234);
        tick(); check("lfsr2", 32'(unit_rand), 32'h11A);
        tick(); check("lfsr3", 32'(unit_rand), 32'h08D);
        tick(); check("lfsr4", 32'(unit_rand), 32'h245);

        // normal transaction on unit 1
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'h05, 3'd1, 7'b1010011);
        pcpi_rs1   = 32'h3F80_0000;
        pcpi_rs2   = 32'h4040_0000;
        check("idle_req", 32'(unit_req), 32'd0);
        tick();
        check("issue_state", 32'(state_test), 32'd1);
        check("issue_req", 32'(unit_req), 32'b10);
        check("issue_wait", 32'(pcpi_wait), 32'd1);
        check("issue_a", unit_a, 32'h3F80_0000);
        check("issue_b", unit_b, 32'h4040_0000);
        check("issue_op", 32'(unit_op), 32'h05);
        tick();
        check("wait_state", 32'(state_test), 32'd2);
        check("wait_req", 32'(unit_req), 32'd0);
        unit_done  = 2'b01;
        unit_res   = {32'h0, 32'hDEAD_BEEF};
        unit_flags = {5'b00000, 5'b10000};
        tick();
        check("other_done_state", 32'(state_test), 32'd2);
        check("other_done_fflags", 32'(fflags), 32'd0);
        unit_done = 2'b00;
        tick();
        unit_done  = 2'b10;
        unit_res   = {32'h4000_0000, 32'hDEAD_BEEF};
        unit_flags = {5'b00001, 5'b10000};
        tick();
        check("resp_ready", 32'(pcpi_ready), 32'd1);
        check("resp_wr", 32'(pcpi_wr), 32'd1);
        check("resp_rd", pcpi_rd, 32'h4000_0000);
        check("resp_fflags", 32'(fflags), 32'b00001);
        check("resp_wait", 32'(pcpi_wait), 32'd0);
        unit_done = 2'b00;
        tick();
        check("post_resp_state", 32'(state_test), 32'd0);
        check("post_resp_ready", 32'(pcpi_ready), 32'd0);
        tick();
        check("reclaim_guard", 32'(state_test), 32'd0);
        pcpi_valid = 1'b0;
        tick();

        // unclaimed: funct3 out of range, then wrong opcode
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'h05, 3'd3, 7'b1010011);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("f3_oob_req", 32'(unit_req), 32'd0);
            check("f3_oob_wait", 32'(pcpi_wait), 32'd0);
            check("f3_oob_ready", 32'(pcpi_ready), 32'd0);
        end
        pcpi_insn = mk_insn(7'h05, 3'd0, 7'b0110011);
        tick();
        check("bad_opc_state", 32'(state_test), 32'd0);
        pcpi_valid = 1'b0;
        tick();

        // watchdog timeout on unit 0
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'h01, 3'd0, 7'b1010011);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("tmo_not_ready", 32'(pcpi_ready), 32'd0);
        end
        tick();
        check("tmo_ready", 32'(pcpi_ready), 32'd1);
        check("tmo_rd", pcpi_rd, 32'h7FC0_0000);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_fflags", 32'(fflags), 32'b10001);
        pcpi_valid = 1'b0;
        tick();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        check("clr_fflags", 32'(fflags), 32'd0);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // abort in WAIT, late done discarded
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'h02, 3'd1, 7'b1010011);
        tick();
        tick();
        check("abort_pre_state", 32'(state_test), 32'd2);
        pcpi_valid = 1'b0;
        tick();
        check("abort_state", 32'(state_test), 32'd0);
        check("abort_wait", 32'(pcpi_wait), 32'd0);
        unit_done  = 2'b10;
        unit_res   = {32'h1234_5678, 32'h0};
        unit_flags = {5'b01000, 5'b00000};
        tick();
        check("abort_ready", 32'(pcpi_ready), 32'd0);
        check("abort_fflags", 32'(fflags), 32'd0);
        unit_done = 2'b00;
        tick();

        // done during ISSUE ignored; then clear with simultaneous new flags
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'h03, 3'd1, 7'b1010011);
        tick();
        unit_done  = 2'b10;
        unit_res   = {32'h1111_1111, 32'h0};
        unit_flags = {5'b00001, 5'b00000};
        tick();
        check("issue_done_ignored", 32'(state_test), 32'd2);
        check("issue_done_ready", 32'(pcpi_ready), 32'd0);
        tick();
        check("a_rd", pcpi_rd, 32'h1111_1111);
        check("a_fflags", 32'(fflags), 32'b00001);
        unit_done  = 2'b00;
        pcpi_valid = 1'b0;
        tick();
        tick();
        pcpi_valid = 1'b1;
        tick();
        tick();
        unit_done  = 2'b10;
        unit_res   = {32'h2222_2222, 32'h0};
        unit_flags = {5'b00100, 5'b00000};
        fflags_clr = 1'b1;
        tick();
        check("b_rd", pcpi_rd, 32'h2222_2222);
        check("clr_new_fflags", 32'(fflags), 32'b00100);
        unit_done  = 2'b00;
        fflags_clr = 1'b0;
        pcpi_valid = 1'b0;
        tick();
        tick();

        // reset asserted in WAIT
        pcpi_valid = 1'b1;
        tick();
        tick();
        check("rstw_pre_state", 32'(state_test), 32'd2);
        reset = 1'b1;
        tick();
        check("rstw_state", 32'(state_test), 32'd0);
        check("rstw_wait", 32'(pcpi_wait), 32'd0);
        check("rstw_rand", 32'(unit_rand), 32'h068);
        check("rstw_fflags", 32'(fflags), 32'd0);
        check("rstw_tmo", 32'(timeout_err), 32'd0);
        check("rstw_a", unit_a, 32'd0);
        pcpi_valid = 1'b0;
        reset      = 1'b0;
        tick();
        check("rstw_lfsr1", 32'(unit_rand), 32'h234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
